// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes and sequencer state encodings shared with the execute-stage decoder
package muldiv_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one shift-add multiply or restoring divide step on a 2*WIDTH accumulator
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nx
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  // mul: {partial, multiplier} adds on lsb then shifts right; div: {rem, dividend} shifts left and trial-subtracts
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, opnd};
    diff   = rem_sh[WIDTH-1:0] - opnd;
    acc_nx = mode ? (ge ? {diff, acc[WIDTH-2:0], 1'b1} : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0})
                  : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide sequencer owning the HI/LO register pair
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e          state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0]   opnd, a_abs, b_abs, quo, rem, hi_nx, lo_nx;
  logic               is_div, neg_q, neg_r, dz, sgn, arith, accept;
  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .mode   (is_div),
    .acc    (acc),
    .opnd   (opnd),
    .acc_nx (acc_nx)
  );
  // request decode, operand magnitudes and sign-fixed results presented on the FIX edge
  always_comb begin
    accept = start && state == MD_IDLE;
    arith  = op <= MD_DIVU;
    sgn    = op == MD_MULT || op == MD_DIV;
    a_abs  = sgn && a[WIDTH-1] ? -a : a;
    b_abs  = sgn && b[WIDTH-1] ? -b : b;
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    hi_nx  = is_div ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
    lo_nx  = is_div ? (dz ? '1 : neg_q ? -quo : quo) : prod[WIDTH-1:0];
  end
  // next state: IDLE -> RUN on an accepted arithmetic op, RUN for WIDTH steps, one FIX cycle
  always_comb begin
    state_nx = state == MD_IDLE ? (accept && arith ? MD_RUN : MD_IDLE)
             : state == MD_RUN  ? (cnt == CW'(WIDTH - 1) ? MD_FIX : MD_RUN)
             : MD_IDLE;
  end
  // state register with registered busy/done so neither is combinational from start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= state_nx != MD_IDLE;
      done  <= state == MD_FIX;
    end
  end
  // operand latch on acceptance, then one iteration per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (accept && arith) begin
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sgn && a[WIDTH-1];
      dz     <= op[1] && b == '0;
      opnd   <= op[1] ? b_abs : a_abs;
      acc    <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
    end else if (state == MD_RUN) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nx;
    end
  end
  // HI/LO change only on an idle move or on the edge leaving FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == MD_FIX) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end else if (accept) begin
      hi <= op == MD_MTHI ? a : hi;
      lo <= op == MD_MTLO ? a : lo;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          reset, start, busy, done;
  logic [2:0]    op;
  logic [W-1:0]  a, b, hi, lo;
  logic [W-1:0]  m_hi, m_lo;
  int            nvec = 0;
  int            nerr = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );
  function automatic logic [63:0] model(logic [2:0] o, logic [31:0] x, logic [31:0] y, logic [63:0] cur);
    longint      sp;
    logic [63:0] up;
    int          q, r;
    case (o)
      3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp; end
      3'd1: begin up = {32'b0, x} * {32'b0, y}; return up; end
      3'd2: begin
        if (y == 0) return {x, 32'hffff_ffff};
        if (x == 32'h8000_0000 && y == 32'hffff_ffff) return {32'h0, x};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hffff_ffff};
        return {x % y, x / y};
      end
      3'd4: return {x, cur[31:0]};
      3'd5: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic arith(logic [2:0] o, logic [31:0] x, logic [31:0] y, int inj);
    logic [63:0] exp;
    int          bc;
    bit          seen, held;
    exp = model(o, x, y, {m_hi, m_lo});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bc = 0; seen = 1'b0; held = 1'b1;
    for (int i = 0; i < 2 * W + 8; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      if (inj != 0 && i == 5) begin
        start = 1'b1; op = inj == 1 ? 3'd5 : 3'd0; a = 32'hdead_beef; b = 32'd3;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(bc), 64'(W + 1));
    chk("hold_during_run", 64'(held), 64'd1);
    chk("busy_in_done_cycle", 64'(busy), 64'd0);
    chk("result_hi_lo", {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
    chk("done_single_pulse", 64'(done), 64'd0);
  endtask
  task automatic mov(logic [2:0] o, logic [31:0] x);
    logic [63:0] exp;
    exp = model(o, x, 32'h0, {m_hi, m_lo});
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    chk("move_hi_lo", {hi, lo}, exp);
    chk("move_busy_done", {62'b0, busy, done}, 64'd0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask
  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;
    arith(3'd0, 32'hffff_fffd, 32'd5, 0);
    arith(3'd1, 32'hffff_ffff, 32'hffff_ffff, 0);
    arith(3'd2, 32'hffff_fff9, 32'd2, 0);
    arith(3'd3, 32'd7, 32'd2, 0);
    arith(3'd3, 32'd7, 32'd0, 0);
    arith(3'd2, 32'hffff_fff9, 32'd0, 0);
    arith(3'd2, 32'h8000_0000, 32'hffff_ffff, 0);
    mov(3'd4, 32'h1234);
    mov(3'd5, 32'h5678);
    arith(3'd0, 32'd5, 32'd7, 1);
    arith(3'd1, 32'd3, 32'd4, 2);
    mov(3'd6, 32'hcafe);
    mov(3'd7, 32'hf00d);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset_clear", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("no_done_after_abort", {busy, done, hi, lo}, 66'd0);
    arith(3'd0, 32'd6, 32'd7, 0);
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
      if (o < 3'd4) arith(o, x, y, 0);
      else mov(o, x);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
